// File: rtl/frame_pkg.sv
// frame_pkg: shared definitions for the frame queue read side (serializer)
// and write side (frame builder).
//   FRAME_W          default frame width (start + 8 data + parity + stop)
//   DEF_CLKS_PER_BIT default serial bit period in clk cycles
//   START_BIT/PARITY_BIT/STOP_BIT  field positions within a frame
//   state_t          serializer FSM states
//   odd_parity()     parity bit that makes data+parity carry an odd count of ones
package frame_pkg;
    localparam int FRAME_W          = 11;
    localparam int DEF_CLKS_PER_BIT = 16;

    localparam int START_BIT  = 0;
    localparam int STOP_BIT   = FRAME_W - 1;
    localparam int PARITY_BIT = FRAME_W - 2;

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, SHIFT} state_t;

    function automatic logic odd_parity(input logic [FRAME_W-4:0] data);
        return ~^data;
    endfunction
endpackage

// File: rtl/bit_timer.sv
// bit_timer: serial bit-period counter.
//   clk, reset : system clock, async active-high reset
//   clr        : synchronous clear of the count
//   en         : count enable (one tick per cycle)
//   tc         : terminal-count strobe, high on the last cycle of a bit period
module bit_timer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [CNT_W-1:0] clk_cnt;

    assign tc = en && (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            clk_cnt <= '0;
        else if (clr || tc)
            clk_cnt <= '0;
        else if (en)
            clk_cnt <= clk_cnt + 1'b1;
    end
endmodule

// File: rtl/frame_serializer.sv
// frame_serializer: pops frames from the frame queue and shifts them out
// LSB-first on tx_out, one bit every CLKS_PER_BIT cycles.
//   clk, reset  : system clock, async active-high reset
//   tx_en       : allows a new frame to start (never aborts one in flight)
//   q_empty     : queue empty flag
//   q_data      : queue registered output, valid the cycle after q_dequeue
//   q_dequeue   : one-cycle pop request (FETCH only)
//   tx_out      : serial line, idles high, driven straight from a flop
//   busy        : FETCH through the end of the last bit
//   frame_done  : one-cycle pulse after the last bit period
//   frame_err   : one-cycle pulse in LOAD when a malformed frame is dropped
// Optional: define FRAME_SERIALIZER_CHECK_EN to check start/stop/parity in
// LOAD and drop bad frames; otherwise frames go out verbatim, frame_err = 0.
import frame_pkg::*;

module frame_serializer #(
    parameter int WIDTH        = FRAME_W,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_en,
    input  logic             q_empty,
    input  logic [WIDTH-1:0] q_data,
    output logic             q_dequeue,
    output logic             tx_out,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_err
);
    localparam int IDX_W = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [IDX_W-1:0] bit_idx;
    logic             tc, last_bit, frame_ok;

    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(CNT_W)) u_timer (
        .clk  (clk),
        .reset(reset),
        .clr  (state == LOAD),
        .en   (state == SHIFT),
        .tc   (tc)
    );

`ifdef FRAME_SERIALIZER_CHECK_EN
    assign frame_ok = (q_data[START_BIT] == 1'b0) && (q_data[WIDTH-1] == 1'b1) &&
                      (^q_data[WIDTH-2:1] == 1'b1);
`else
    assign frame_ok = 1'b1;
`endif

    assign last_bit = (bit_idx == IDX_W'(WIDTH - 1));
    // The shift register refills with ones, so it is all ones whenever no
    // frame is in flight and tx_out idles high without extra muxing.
    assign tx_out   = shreg[0];
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        q_dequeue = 1'b0;
        frame_err = 1'b0;
        case (state)
            IDLE:  if (tx_en && !q_empty) state_nxt = FETCH;
            FETCH: begin
                q_dequeue = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: begin
                if (frame_ok) begin
                    state_nxt = SHIFT;
                end else begin
                    frame_err = 1'b1;
                    state_nxt = IDLE;
                end
            end
            SHIFT: if (tc && last_bit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg      <= '1;
            bit_idx    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == SHIFT) && tc && last_bit;
            case (state)
                LOAD: begin
                    bit_idx <= '0;
                    if (frame_ok) shreg <= q_data;
                end
                SHIFT: begin
                    if (tc) begin
                        shreg   <= {1'b1, shreg[WIDTH-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_serializer.sv
module tb_frame_serializer;
    localparam int W   = 11;
    localparam int CPB = 4;
    localparam int FT  = W * CPB;

    logic         clk = 1'b0;
    logic         reset, tx_en, q_empty, q_dequeue, tx_out, busy, frame_done, frame_err;
    logic [W-1:0] q_data = '1;

    int vectors = 0;
    int errors  = 0;

    // Registered-output queue model
    logic [W-1:0] qmem [0:15];
    int wr_ptr = 0, rd_ptr = 0;
    int n_deq = 0, n_done = 0, n_err = 0;

    assign q_empty = (wr_ptr == rd_ptr);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (q_dequeue && !q_empty) begin
            q_data <= qmem[rd_ptr % 16];
            rd_ptr <= rd_ptr + 1;
        end
        if (q_dequeue)  n_deq  <= n_deq + 1;
        if (frame_done) n_done <= n_done + 1;
        if (frame_err)  n_err  <= n_err + 1;
    end

    frame_serializer #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_en     (tx_en),
        .q_empty   (q_empty),
        .q_data    (q_data),
        .q_dequeue (q_dequeue),
        .tx_out    (tx_out),
        .busy      (busy),
        .frame_done(frame_done),
        .frame_err (frame_err)
    );

    task automatic push(input logic [W-1:0] f);
        qmem[wr_ptr % 16] = f;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until the FETCH cycle (q_dequeue high) or give up.
    task automatic wait_deq(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (q_dequeue) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tx_en = 1'b0;
        #12;
        vectors++;
        if (tx_out !== 1'b1 || busy !== 1'b0 || q_dequeue !== 1'b0 ||
            frame_done !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: tx=%b busy=%b deq=%b done=%b err=%b, required 1 0 0 0 0",
                     tx_out, busy, q_dequeue, frame_done, frame_err);
        end
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        logic [W-1:0] f = 11'h74A;
        bit ok;
        int d0 = n_deq;
        push(f);
        tx_en = 1'b1;
        wait_deq(ok);
        vectors++;
        if (!ok || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_fetch: dequeue_seen=%0d busy=%b, required 1 1", ok, busy);
        end
        step();
        step();
        for (int i = 0; i < FT; i++) begin
            vectors++;
            if (tx_out !== f[i/CPB]) begin
                errors++;
                $display("FAIL single_tx cycle %0d: got %b, required %b", i, tx_out, f[i/CPB]);
            end
            step();
        end
        vectors++;
        if (frame_done !== 1'b1 || busy !== 1'b0 || tx_out !== 1'b1) begin
            errors++;
            $display("FAIL single_done_at_44: done=%b busy=%b tx=%b, required 1 0 1",
                     frame_done, busy, tx_out);
        end
        step();
        vectors++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL single_done_width: done=%b, required 0", frame_done);
        end
        repeat (5) step();
        vectors++;
        if (n_deq - d0 != 1) begin
            errors++;
            $display("FAIL single_deq_count: got %0d, required 1", n_deq - d0);
        end
        tx_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] f1 = 11'h74A;
`ifdef FRAME_SERIALIZER_CHECK_EN
        logic [W-1:0] f2 = 11'h74A;
`else
        logic [W-1:0] f2 = 11'h401;
`endif
        bit ok;
        int d0 = n_deq;
        int c0 = n_done;
        push(f1);
        push(f2);
        tx_en = 1'b1;
        wait_deq(ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_first_fetch: no dequeue seen, required one");
        end
        step();
        step();
        for (int i = 0; i < FT; i++) begin
            vectors++;
            if (tx_out !== f1[i/CPB]) begin
                errors++;
                $display("FAIL b2b_tx1 cycle %0d: got %b, required %b", i, tx_out, f1[i/CPB]);
            end
            step();
        end
        // Three high gap cycles: IDLE, FETCH, LOAD
        vectors++;
        if (frame_done !== 1'b1 || tx_out !== 1'b1 || q_dequeue !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap_idle: done=%b tx=%b deq=%b, required 1 1 0",
                     frame_done, tx_out, q_dequeue);
        end
        step();
        vectors++;
        if (q_dequeue !== 1'b1 || tx_out !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap_fetch: deq=%b tx=%b, required 1 1", q_dequeue, tx_out);
        end
        step();
        vectors++;
        if (q_dequeue !== 1'b0 || tx_out !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap_load: deq=%b tx=%b busy=%b, required 0 1 1",
                     q_dequeue, tx_out, busy);
        end
        step();
        for (int i = 0; i < FT; i++) begin
            vectors++;
            if (tx_out !== f2[i/CPB]) begin
                errors++;
                $display("FAIL b2b_tx2 cycle %0d: got %b, required %b", i, tx_out, f2[i/CPB]);
            end
            step();
        end
        tx_en = 1'b0;
        vectors++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done2: done=%b, required 1", frame_done);
        end
        repeat (5) step();
        vectors++;
        if (n_deq - d0 != 2 || n_done - c0 != 2) begin
            errors++;
            $display("FAIL b2b_counts: deq=%0d done=%0d, required 2 2", n_deq - d0, n_done - c0);
        end
    endtask

    task automatic test_empty_gating();
        tx_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            vectors++;
            if (q_dequeue !== 1'b0 || tx_out !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL empty_idle cycle %0d: deq=%b tx=%b busy=%b, required 0 1 0",
                         i, q_dequeue, tx_out, busy);
            end
        end
        tx_en = 1'b0;
        push(11'h74A);
        for (int i = 0; i < 30; i++) begin
            step();
            vectors++;
            if (q_dequeue !== 1'b0 || tx_out !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL gated_idle cycle %0d: deq=%b tx=%b busy=%b, required 0 1 0",
                         i, q_dequeue, tx_out, busy);
            end
        end
    endtask

    // One frame is still queued from the gating test; add one more so the
    // queue stays non-empty after tx_en drops.
    task automatic test_tx_en_drop();
        logic [W-1:0] f = 11'h74A;
        bit ok;
        push(f);
        tx_en = 1'b1;
        wait_deq(ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL drop_fetch: no dequeue seen, required one");
        end
        step();
        step();
        for (int i = 0; i < FT; i++) begin
            if (i == 3 * CPB) tx_en = 1'b0;
            vectors++;
            if (tx_out !== f[i/CPB]) begin
                errors++;
                $display("FAIL drop_tx cycle %0d: got %b, required %b", i, tx_out, f[i/CPB]);
            end
            step();
        end
        vectors++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL drop_done: done=%b, required 1", frame_done);
        end
        for (int i = 0; i < 50; i++) begin
            step();
            vectors++;
            if (q_dequeue !== 1'b0 || busy !== 1'b0 || q_empty !== 1'b0) begin
                errors++;
                $display("FAIL drop_stays_idle cycle %0d: deq=%b busy=%b empty=%b, required 0 0 0",
                         i, q_dequeue, busy, q_empty);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] f = 11'h74A;
        bit ok;
        int c0;
        tx_en = 1'b1;
        wait_deq(ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_fetch: no dequeue seen, required one");
        end
        step();
        step();
        repeat (5 * CPB + 1) step();
        vectors++;
        if (tx_out !== f[5]) begin
            errors++;
            $display("FAIL rst_pre_bit5: tx=%b, required %b", tx_out, f[5]);
        end
        c0 = n_done;
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_immediate: tx=%b busy=%b, required 1 0", tx_out, busy);
        end
        #13;
        reset = 1'b0;
        push(f);
        wait_deq(ok);
        vectors++;
        if (!ok || n_done != c0) begin
            errors++;
            $display("FAIL rst_no_done_refetch: dequeue_seen=%0d done_delta=%0d, required 1 0",
                     ok, n_done - c0);
        end
        step();
        step();
        for (int i = 0; i < FT; i++) begin
            vectors++;
            if (tx_out !== f[i/CPB]) begin
                errors++;
                $display("FAIL rst_next_tx cycle %0d: got %b, required %b", i, tx_out, f[i/CPB]);
            end
            step();
        end
        vectors++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL rst_next_done: done=%b, required 1", frame_done);
        end
        tx_en = 1'b0;
        repeat (5) step();
    endtask

`ifdef FRAME_SERIALIZER_CHECK_EN
    task automatic test_check_err();
        logic [W-1:0] g = 11'h74A;
        bit ok;
        int c0 = n_done;
        int e0 = n_err;
        push(11'h74B);
        push(g);
        tx_en = 1'b1;
        wait_deq(ok);
        step();
        vectors++;
        if (!ok || frame_err !== 1'b1 || tx_out !== 1'b1) begin
            errors++;
            $display("FAIL chk_err_in_load: dequeue_seen=%0d err=%b tx=%b, required 1 1 1",
                     ok, frame_err, tx_out);
        end
        step();
        vectors++;
        if (frame_err !== 1'b0 || tx_out !== 1'b1 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL chk_after_drop: err=%b tx=%b done=%b, required 0 1 0",
                     frame_err, tx_out, frame_done);
        end
        wait_deq(ok);
        step();
        step();
        for (int i = 0; i < FT; i++) begin
            vectors++;
            if (tx_out !== g[i/CPB]) begin
                errors++;
                $display("FAIL chk_good_tx cycle %0d: got %b, required %b", i, tx_out, g[i/CPB]);
            end
            step();
        end
        tx_en = 1'b0;
        repeat (3) step();
        vectors++;
        if (!ok || n_done - c0 != 1 || n_err - e0 != 1) begin
            errors++;
            $display("FAIL chk_counts: done=%0d err=%0d, required 1 1", n_done - c0, n_err - e0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_empty_gating();
        test_tx_en_drop();
        test_async_reset();
`ifdef FRAME_SERIALIZER_CHECK_EN
        test_check_err();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
